plot_framebuffer: RTL and testbench

Receiving end of the plot interface driven by the circle/reuleaux/fillscreen drawing engines. Accepts one (vga_x, vga_y, vga_colour, plot) write per cycle, clips off-screen coordinates, and stores pixels in a 160x120x3-bit frame memory. Provides a synchronous read port, a hardware clear sequence, and accept/reject counters. Benches use it as a checkable stand-in for vga_adapter; it can also back a scan-out path.

---
 rtl/plot_framebuffer.sv | 137 +++++++++++++
 tb/tb_plot_framebuffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/plot_framebuffer.sv
// Plot-interface frame store: clips incoming pixels, keeps a 160x120x3 frame,
// offers a registered read port, a full-frame clear sweep and saturating counters.
module plot_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             plot,
    input  logic [7:0]       vga_x,
    input  logic [6:0]       vga_y,
    input  logic [2:0]       vga_colour,
    input  logic             clear_start,
    input  logic [2:0]       clear_colour,
    output logic             busy,
    input  logic [7:0]       rd_x,
    input  logic [6:0]       rd_y,
    output logic [2:0]       rd_colour,
    output logic [CNT_W-1:0] plot_count,
    output logic [CNT_W-1:0] reject_count
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [7:0]  X_LIM     = WIDTH[7:0];
    localparam logic [6:0]  Y_LIM     = HEIGHT[6:0];
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [14:0]      sweep_q, sweep_d;
    logic [2:0]       clr_colour_q, clr_colour_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] plot_count_q, plot_count_d;
    logic [CNT_W-1:0] reject_count_q, reject_count_d;
    logic [2:0]       rd_colour_q, rd_colour_d;

    logic [2:0]  mem [0:DEPTH-1];
    logic        mem_we;
    logic [14:0] mem_waddr;
    logic [2:0]  mem_wdata;

    logic [14:0] plot_addr;
    logic [14:0] rd_addr;
    logic        plot_in_range;
    logic        rd_in_range;

    // y*160 + x expressed as (y<<7) + (y<<5) + x so no multiplier is needed.
    assign plot_addr     = ({8'd0, vga_y} << 7) + ({8'd0, vga_y} << 5) + {7'd0, vga_x};
    assign rd_addr       = ({8'd0, rd_y} << 7) + ({8'd0, rd_y} << 5) + {7'd0, rd_x};
    assign plot_in_range = (vga_x < X_LIM) && (vga_y < Y_LIM);
    assign rd_in_range   = (rd_x < X_LIM) && (rd_y < Y_LIM);

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        clr_colour_d   = clr_colour_q;
        busy_d         = busy_q;
        plot_count_d   = plot_count_q;
        reject_count_d = reject_count_q;
        mem_we         = 1'b0;
        mem_waddr      = plot_addr;
        mem_wdata      = vga_colour;

        case (state_q)
            IDLE: begin
                // A clear wins over a same-cycle plot; that plot still counts as rejected.
                if (clear_start) begin
                    state_d        = CLEAR;
                    clr_colour_d   = clear_colour;
                    sweep_d        = 15'd0;
                    busy_d         = 1'b1;
                    plot_count_d   = '0;
                    reject_count_d = plot ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
                end else if (plot) begin
                    if (plot_in_range) begin
                        mem_we = 1'b1;
                        if (plot_count_q != CNT_MAX) plot_count_d = plot_count_q + 1'b1;
                    end else if (reject_count_q != CNT_MAX) begin
                        reject_count_d = reject_count_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = clr_colour_q;
                if (plot && reject_count_q != CNT_MAX) reject_count_d = reject_count_q + 1'b1;
                if (sweep_q == LAST_ADDR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + 15'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_colour_d = rd_in_range ? mem[rd_addr] : 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            sweep_q        <= 15'd0;
            clr_colour_q   <= 3'd0;
            busy_q         <= 1'b0;
            plot_count_q   <= '0;
            reject_count_q <= '0;
            rd_colour_q    <= 3'd0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            clr_colour_q   <= clr_colour_d;
            busy_q         <= busy_d;
            plot_count_q   <= plot_count_d;
            reject_count_q <= reject_count_d;
            rd_colour_q    <= rd_colour_d;
        end
    end

    // Memory is never reset, but a reset edge must not commit the pending sweep write.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    end

    assign busy         = busy_q;
    assign rd_colour    = rd_colour_q;
    assign plot_count   = plot_count_q;
    assign reject_count = reject_count_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer; counters are built narrow so saturation
// is reachable in a few thousand cycles.
module tb_plot_framebuffer;

    localparam int TB_CNT_W = 12;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clock;
    logic                reset;
    logic                plot;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [2:0]          vga_colour;
    logic                clear_start;
    logic [2:0]          clear_colour;
    logic                busy;
    logic [7:0]          rd_x;
    logic [6:0]          rd_y;
    logic [2:0]          rd_colour;
    logic [TB_CNT_W-1:0] plot_count;
    logic [TB_CNT_W-1:0] reject_count;

    int testCount = 0;
    int failCount = 0;
    int busyCycles;

    plot_framebuffer #(
        .WIDTH (160),
        .HEIGHT(120),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .plot        (plot),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .clear_start (clear_start),
        .clear_colour(clear_colour),
        .busy        (busy),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_colour   (rd_colour),
        .plot_count  (plot_count),
        .reject_count(reject_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        vga_x      = x;
        vga_y      = y;
        vga_colour = c;
        plot       = 1'b1;
        tick();
        plot       = 1'b0;
    endtask

    task automatic readPixel(input string tag, input logic [7:0] x, input logic [6:0] y, input logic [2:0] expected);
        rd_x = x;
        rd_y = y;
        tick();
        checkOutput(tag, {29'd0, rd_colour}, {29'd0, expected});
    endtask

    task automatic startClear(input logic [2:0] c);
        clear_colour = c;
        clear_start  = 1'b1;
        tick();
        clear_start  = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 20000) begin
            cycles++;
            tick();
        end
        if (busy) checkOutput("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        plot         = 1'b0;
        vga_x        = 8'd0;
        vga_y        = 7'd0;
        vga_colour   = 3'd0;
        clear_start  = 1'b0;
        clear_colour = 3'd0;
        rd_x         = 8'd0;
        rd_y         = 7'd0;
        repeat (2) tick();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rd_colour", {29'd0, rd_colour}, 32'd0);
        checkOutput("reset_plot_count", 32'(plot_count), 32'd0);
        checkOutput("reset_reject_count", 32'(reject_count), 32'd0);
        reset = 1'b0;
        tick();

        // Full clear to black and read-back
        startClear(3'b000);
        waitIdle(busyCycles);
        checkOutput("clear_busy_cycles", 32'(busyCycles), 32'd19200);
        readPixel("clear_0_0", 8'd0, 7'd0, 3'b000);
        readPixel("clear_159_119", 8'd159, 7'd119, 3'b000);
        readPixel("clear_80_60", 8'd80, 7'd60, 3'b000);

        // Single plot, read one cycle later
        applyStimulus(8'd80, 7'd60, 3'b011);
        readPixel("single_80_60", 8'd80, 7'd60, 3'b011);
        checkOutput("single_plot_count", 32'(plot_count), 32'd1);
        checkOutput("single_reject_count", 32'(reject_count), 32'd0);

        // Clipping, starting from fresh counters
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(8'd160, 7'd0, 3'b111);
        applyStimulus(8'd0, 7'd120, 3'b111);
        applyStimulus(8'd200, 7'd100, 3'b111);
        applyStimulus(8'd159, 7'd119, 3'b101);
        checkOutput("clip_reject_count", 32'(reject_count), 32'd3);
        checkOutput("clip_plot_count", 32'(plot_count), 32'd1);
        readPixel("clip_159_119", 8'd159, 7'd119, 3'b101);
        readPixel("clip_0_0", 8'd0, 7'd0, 3'b000);
        readPixel("mem_survives_reset", 8'd80, 7'd60, 3'b011);

        // Clear with a same-cycle plot, plots during the sweep, ignored re-trigger
        vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'b010; plot = 1'b1;
        startClear(3'b111);
        plot = 1'b0;
        checkOutput("clr_prio_reject", 32'(reject_count), 32'd1);
        checkOutput("clr_prio_plot_count", 32'(plot_count), 32'd0);
        checkOutput("clr_busy_high", {31'd0, busy}, 32'd1);
        repeat (9) tick();
        for (int i = 0; i < 4; i++) applyStimulus(8'd5, 7'd5, 3'b010);
        checkOutput("during_clear_reject", 32'(reject_count), 32'd5);
        startClear(3'b010);
        checkOutput("retrigger_reject", 32'(reject_count), 32'd5);
        waitIdle(busyCycles);
        readPixel("after_clear_5_5", 8'd5, 7'd5, 3'b111);
        readPixel("after_clear_0_0", 8'd0, 7'd0, 3'b111);
        readPixel("after_clear_159_119", 8'd159, 7'd119, 3'b111);
        checkOutput("after_clear_plot_count", 32'(plot_count), 32'd0);

        // Reset while sweep counter is 500
        applyStimulus(8'd120, 7'd3, 3'b001);
        startClear(3'b110);
        repeat (500) tick();
        checkOutput("midclear_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midclear_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("midclear_plot_count", 32'(plot_count), 32'd0);
        checkOutput("midclear_reject_count", 32'(reject_count), 32'd0);
        reset = 1'b0;
        readPixel("midclear_3_3", 8'd3, 7'd3, 3'b110);
        readPixel("midclear_addr499", 8'd19, 7'd3, 3'b110);
        readPixel("midclear_addr500", 8'd20, 7'd3, 3'b111);
        readPixel("midclear_addr600", 8'd120, 7'd3, 3'b001);

        // Read-before-write on the same address
        applyStimulus(8'd10, 7'd10, 3'b100);
        rd_x = 8'd10;
        rd_y = 7'd10;
        applyStimulus(8'd10, 7'd10, 3'b001);
        checkOutput("rbw_old_value", {29'd0, rd_colour}, {29'd0, 3'b100});
        readPixel("rbw_new_value", 8'd10, 7'd10, 3'b001);
        checkOutput("rbw_plot_count", 32'(plot_count), 32'd2);
        readPixel("rd_oob_x", 8'd160, 7'd0, 3'b000);
        readPixel("rd_oob_y", 8'd0, 7'd120, 3'b000);

        // Counter saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'b011; plot = 1'b1;
        repeat (CNT_MAX + 5) tick();
        plot = 1'b0;
        checkOutput("sat_plot_count", 32'(plot_count), CNT_MAX);
        applyStimulus(8'd200, 7'd0, 3'b000);
        checkOutput("sat_reject_count", 32'(reject_count), 32'd1);
        checkOutput("sat_plot_hold", 32'(plot_count), CNT_MAX);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
